// File: rtl/cbc_pkg.sv
// Shared constants and state encoding for the CBC chaining stage.
package cbc_pkg;

    localparam int unsigned CBC_BSIZE = 128;
    localparam int unsigned CBC_CNT_W = 32;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } cbc_state_e;

endpackage

// File: rtl/cbc_chain_reg.sv
// Chaining value and saved ciphertext storage for CBC; IV load has priority
// over the post-core chain updates.
module cbc_chain_reg
    import cbc_pkg::*;
#(
    parameter int unsigned BSIZE = CBC_BSIZE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_iv,
    input  logic [BSIZE-1:0] iv_in,
    input  logic             save_ct,
    input  logic [BSIZE-1:0] blk_in,
    input  logic             upd_enc,
    input  logic [BSIZE-1:0] core_in,
    input  logic             upd_dec,
    output logic [BSIZE-1:0] chain
);

    logic [BSIZE-1:0] chain_q, chain_d;
    logic [BSIZE-1:0] saved_ct_q, saved_ct_d;

    always_comb begin
        chain_d    = chain_q;
        saved_ct_d = saved_ct_q;
        if (load_iv) begin
            chain_d = iv_in;
        end else if (upd_enc) begin
            chain_d = core_in;
        end else if (upd_dec) begin
            chain_d = saved_ct_q;
        end
        if (save_ct) begin
            saved_ct_d = blk_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q    <= '0;
            saved_ct_q <= '0;
        end else begin
            chain_q    <= chain_d;
            saved_ct_q <= saved_ct_d;
        end
    end

    assign chain = chain_q;

endmodule

// File: rtl/block_cbc_chainer.sv
// CBC chaining stage around a 128-bit block cipher core, one block in flight.
// Optional CBC_ECB_BYPASS_EN adds ecb_mode, which turns the stage into ECB pass-through.
module block_cbc_chainer
    import cbc_pkg::*;
#(
    parameter int unsigned BSIZE = CBC_BSIZE,
    parameter int unsigned CNT_W = CBC_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BSIZE-1:0] iv_in,
    input  logic             iv_load,
    input  logic             mode_decrypt,
`ifdef CBC_ECB_BYPASS_EN
    input  logic             ecb_mode,
`endif
    input  logic [BSIZE-1:0] blk_in,
    input  logic             blk_in_valid,
    output logic             blk_in_ready,
    output logic [BSIZE-1:0] core_out,
    output logic             core_out_valid,
    input  logic             core_out_ready,
    input  logic [BSIZE-1:0] core_in,
    input  logic             core_in_valid,
    output logic             core_in_ready,
    output logic [BSIZE-1:0] blk_out,
    output logic             blk_out_valid,
    input  logic             blk_out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] block_count
);

    cbc_state_e       state_q, state_d;
    logic [BSIZE-1:0] core_out_q, core_out_d;
    logic [BSIZE-1:0] blk_out_q, blk_out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;

    logic             load_iv_c, save_ct_c, upd_enc_c, upd_dec_c;
    logic             accept_c;
    logic             ecb_in_c, ecb_fly_c;
    logic [BSIZE-1:0] chain_c;

`ifdef CBC_ECB_BYPASS_EN
    logic ecb_q, ecb_d;

    always_comb begin
        ecb_d = ecb_q;
        if (accept_c) begin
            ecb_d = ecb_mode;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ecb_q <= 1'b0;
        end else begin
            ecb_q <= ecb_d;
        end
    end

    assign ecb_in_c  = ecb_mode;
    assign ecb_fly_c = ecb_q;
`else
    assign ecb_in_c  = 1'b0;
    assign ecb_fly_c = 1'b0;
`endif

    assign accept_c = (state_q == IDLE) && !iv_load && blk_in_valid;

    // Next-state, data path and chain-register control
    always_comb begin
        state_d    = state_q;
        core_out_d = core_out_q;
        blk_out_d  = blk_out_q;
        count_d    = count_q;
        mode_d     = mode_q;
        load_iv_c  = 1'b0;
        save_ct_c  = 1'b0;
        upd_enc_c  = 1'b0;
        upd_dec_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iv_load) begin
                    load_iv_c = 1'b1;
                    count_d   = '0;
                end else if (blk_in_valid) begin
                    mode_d = mode_decrypt;
                    if (mode_decrypt == MODE_DEC) begin
                        core_out_d = blk_in;
                        save_ct_c  = !ecb_in_c;
                    end else begin
                        core_out_d = blk_in ^ (ecb_in_c ? '0 : chain_c);
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                if (core_out_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_in_valid) begin
                    if (mode_q == MODE_DEC) begin
                        blk_out_d = core_in ^ (ecb_fly_c ? '0 : chain_c);
                        upd_dec_c = !ecb_fly_c;
                    end else begin
                        blk_out_d = core_in;
                        upd_enc_c = !ecb_fly_c;
                    end
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (blk_out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            core_out_q <= '0;
            blk_out_q  <= '0;
            count_q    <= '0;
            mode_q     <= MODE_ENC;
        end else begin
            state_q    <= state_d;
            core_out_q <= core_out_d;
            blk_out_q  <= blk_out_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
        end
    end

    cbc_chain_reg #(
        .BSIZE (BSIZE)
    ) u_chain (
        .clock   (clock),
        .reset   (reset),
        .load_iv (load_iv_c),
        .iv_in   (iv_in),
        .save_ct (save_ct_c),
        .blk_in  (blk_in),
        .upd_enc (upd_enc_c),
        .core_in (core_in),
        .upd_dec (upd_dec_c),
        .chain   (chain_c)
    );

    // Handshake flags decode straight from the state register
    assign blk_in_ready   = (state_q == IDLE) && !iv_load;
    assign core_out_valid = (state_q == SEND);
    assign core_in_ready  = (state_q == WAIT);
    assign blk_out_valid  = (state_q == EMIT);
    assign busy           = (state_q != IDLE);
    assign core_out       = core_out_q;
    assign blk_out        = blk_out_q;
    assign block_count    = count_q;

endmodule

// File: tb/tb_block_cbc_chainer.sv
// Self-checking bench for block_cbc_chainer: directed table, corner sequences,
// and randomized traffic against a CBC reference model.
module tb_block_cbc_chainer;

    localparam int unsigned BSIZE = 128;
    localparam int unsigned CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [BSIZE-1:0] iv_in = '0;
    logic             iv_load = 1'b0;
    logic             mode_decrypt = 1'b0;
    logic [BSIZE-1:0] blk_in = '0;
    logic             blk_in_valid = 1'b0;
    logic             blk_in_ready;
    logic [BSIZE-1:0] core_out;
    logic             core_out_valid;
    logic             core_out_ready = 1'b0;
    logic [BSIZE-1:0] core_in = '0;
    logic             core_in_valid = 1'b0;
    logic             core_in_ready;
    logic [BSIZE-1:0] blk_out;
    logic             blk_out_valid;
    logic             blk_out_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] block_count;
`ifdef CBC_ECB_BYPASS_EN
    logic             ecb_mode = 1'b0;
`endif

    block_cbc_chainer dut (
        .clock          (clock),
        .reset          (reset),
        .iv_in          (iv_in),
        .iv_load        (iv_load),
        .mode_decrypt   (mode_decrypt),
`ifdef CBC_ECB_BYPASS_EN
        .ecb_mode       (ecb_mode),
`endif
        .blk_in         (blk_in),
        .blk_in_valid   (blk_in_valid),
        .blk_in_ready   (blk_in_ready),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .core_in        (core_in),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .blk_out        (blk_out),
        .blk_out_valid  (blk_out_valid),
        .blk_out_ready  (blk_out_ready),
        .busy           (busy),
        .block_count    (block_count)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state and core stub selection
    bit               core_identity = 1'b1;
    logic [BSIZE-1:0] m_chain = '0;
    logic [CNT_W-1:0] m_count = '0;
    logic [BSIZE-1:0] key = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    function automatic logic [BSIZE-1:0] core_fn(input logic [BSIZE-1:0] x);
        if (core_identity) return x;
        return {x[BSIZE-2:0], x[BSIZE-1]} ^ key;
    endfunction

    // CBC: enc C = E(P ^ prev), dec P = D(C) ^ prev, prev becomes the ciphertext
    task automatic model_step(input logic dec, input logic [BSIZE-1:0] blk,
                              output logic [BSIZE-1:0] exp_co, output logic [BSIZE-1:0] exp_bo);
        if (dec) begin
            exp_co  = blk;
            exp_bo  = core_fn(blk) ^ m_chain;
            m_chain = blk;
        end else begin
            exp_co  = blk ^ m_chain;
            exp_bo  = core_fn(exp_co);
            m_chain = exp_bo;
        end
        m_count = m_count + 1;
    endtask

    task automatic check(input string name, input logic [BSIZE-1:0] act, input logic [BSIZE-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_iv(input logic [BSIZE-1:0] v);
        iv_in   = v;
        iv_load = 1'b1;
        @(negedge clock);
        iv_load = 1'b0;
        m_chain = v;
        m_count = '0;
    endtask

    task automatic put_block(input logic [BSIZE-1:0] blk, input logic dec);
        int n = 0;
        blk_in       = blk;
        mode_decrypt = dec;
        blk_in_valid = 1'b1;
        #1;
        while (!blk_in_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("blk_in_ready_wait", 128'(blk_in_ready), 128'(1));
        @(negedge clock);
        blk_in_valid = 1'b0;
        blk_in       = ~blk;
        mode_decrypt = ~dec;
        check("core_out_valid_latency", 128'(core_out_valid), 128'(1));
    endtask

    task automatic core_xchg(input int s1, input int s2, output logic [BSIZE-1:0] co);
        logic [BSIZE-1:0] co0;
        co0 = core_out;
        repeat (s1) begin
            @(negedge clock);
            check("core_out_hold", core_out, co0);
        end
        co = core_out;
        core_out_ready = 1'b1;
        @(negedge clock);
        core_out_ready = 1'b0;
        check("core_in_ready_wait", 128'(core_in_ready), 128'(1));
        repeat (s2) @(negedge clock);
        core_in       = core_fn(co);
        core_in_valid = 1'b1;
        @(negedge clock);
        core_in_valid = 1'b0;
        core_in       = {$urandom, $urandom, $urandom, $urandom};
        check("blk_out_valid_latency", 128'(blk_out_valid), 128'(1));
    endtask

    task automatic take_out(input int s3, output logic [BSIZE-1:0] bo);
        logic [BSIZE-1:0] bo0;
        logic [CNT_W-1:0] cnt0;
        bo0  = blk_out;
        cnt0 = block_count;
        repeat (s3) begin
            @(negedge clock);
            check("emit_hold_valid", 128'(blk_out_valid), 128'(1));
            check("emit_hold_data", blk_out, bo0);
            check("emit_hold_in_ready", 128'(blk_in_ready), 128'(0));
            check("emit_hold_count", 128'(block_count), 128'(cnt0));
        end
        bo = blk_out;
        blk_out_ready = 1'b1;
        @(negedge clock);
        blk_out_ready = 1'b0;
    endtask

    task automatic do_block(input logic [BSIZE-1:0] blk, input logic dec,
                            input int s1, input int s2, input int s3);
        logic [BSIZE-1:0] co, bo, exp_co, exp_bo;
        put_block(blk, dec);
        core_xchg(s1, s2, co);
        take_out(s3, bo);
        model_step(dec, blk, exp_co, exp_bo);
        check("core_out", co, exp_co);
        check("blk_out", bo, exp_bo);
        check("block_count", 128'(block_count), 128'(m_count));
    endtask

    typedef struct {
        logic             do_iv;
        logic [BSIZE-1:0] iv;
        logic             dec;
        logic [BSIZE-1:0] blk;
        logic [BSIZE-1:0] exp_co;
        logic [BSIZE-1:0] exp_bo;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
        $fatal(1);
    end

    initial begin
        logic [BSIZE-1:0] co, bo, exp_co, exp_bo, p;
        logic dec;

        vecs[0] = '{1'b1, 128'h1, 1'b0, 128'h3, 128'h2, 128'h2, 32'd1};
        vecs[1] = '{1'b0, 128'h0, 1'b0, 128'h2, 128'h0, 128'h0, 32'd2};
        vecs[2] = '{1'b1, 128'h1, 1'b1, 128'h5, 128'h5, 128'h4, 32'd1};
        vecs[3] = '{1'b0, 128'h0, 1'b1, 128'h7, 128'h7, 128'h2, 32'd2};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_blk_in_ready", 128'(blk_in_ready), 128'(1));
        check("rst_core_out_valid", 128'(core_out_valid), 128'(0));
        check("rst_blk_out_valid", 128'(blk_out_valid), 128'(0));
        check("rst_core_in_ready", 128'(core_in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_count", 128'(block_count), 128'(0));
        check("rst_core_out", core_out, 128'h0);
        check("rst_blk_out", blk_out, 128'h0);
        @(negedge clock);

        // Directed table with an identity core
        core_identity = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_iv) load_iv(vecs[i].iv);
            put_block(vecs[i].blk, vecs[i].dec);
            core_xchg(0, 0, co);
            take_out(0, bo);
            model_step(vecs[i].dec, vecs[i].blk, exp_co, exp_bo);
            check("tbl_core_out", co, vecs[i].exp_co);
            check("tbl_blk_out", bo, vecs[i].exp_bo);
            check("tbl_count", 128'(block_count), 128'(vecs[i].exp_cnt));
        end

        // Consumer stalls ten cycles in EMIT
        do_block(128'h11, 1'b0, 0, 0, 10);

        // Reset while the core is presenting a result
        put_block(128'h55, 1'b0);
        core_out_ready = 1'b1;
        @(negedge clock);
        core_out_ready = 1'b0;
        core_in        = 128'h99;
        core_in_valid  = 1'b1;
        reset          = 1'b1;
        #1;
        check("midrst_blk_out_valid", 128'(blk_out_valid), 128'(0));
        @(negedge clock);
        check("midrst_busy", 128'(busy), 128'(0));
        reset         = 1'b0;
        @(negedge clock);
        core_in_valid = 1'b0;
        check("postrst_blk_out_valid", 128'(blk_out_valid), 128'(0));
        check("postrst_count", 128'(block_count), 128'(0));
        m_chain = '0;
        m_count = '0;
        do_block(128'h0A, 1'b0, 0, 0, 0);
        check("postrst_chain_zero", m_chain, 128'h0A);

        // IV load in the same IDLE cycle as a block, then IV load during SEND
        iv_in        = 128'hA5A5;
        iv_load      = 1'b1;
        blk_in       = 128'h3C;
        blk_in_valid = 1'b1;
        mode_decrypt = 1'b0;
        #1;
        check("ivprio_blk_in_ready", 128'(blk_in_ready), 128'(0));
        @(negedge clock);
        iv_load = 1'b0;
        m_chain = 128'hA5A5;
        m_count = '0;
        #1;
        check("ivprio_not_accepted", 128'(busy), 128'(0));
        put_block(128'h3C, 1'b0);
        iv_in   = 128'hDEAD;
        iv_load = 1'b1;
        @(negedge clock);
        iv_load = 1'b0;
        core_xchg(0, 0, co);
        take_out(0, bo);
        model_step(1'b0, 128'h3C, exp_co, exp_bo);
        check("ivprio_core_out", co, exp_co);
        check("ivprio_blk_out", bo, exp_bo);
        check("ivprio_count", 128'(block_count), 128'(1));
        do_block(128'h77, 1'b0, 0, 0, 0);

        // Randomized traffic against the reference model with a non-trivial core
        core_identity = 1'b0;
        load_iv({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) load_iv({$urandom, $urandom, $urandom, $urandom});
            p   = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            do_block(p, dec, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
